// File: rtl/led_pulse_stretcher.sv
// led_pulse_stretcher
//   Turns 1-cycle event pulses into LED activity a person can see. A trigger
//   lights the channel solid for HOLD_TICKS time-base ticks. The channel then
//   fades out over 2^PWM_BITS-1 ticks with PWM, and goes dark.
//   One shared prescaler and one shared PWM counter serve every channel.
//   Each channel is its own lane instance.
// Ports
//   CLK    system clock, all logic on posedge
//   RST_N  asynchronous active-low reset
//   EN     1 = time base runs; 0 = ticks frozen (PWM keeps running)
//   TRIG   [N] per-channel event pulse; held high retriggers every cycle
//   LED    [N] registered LED drive
//   BUSY   [N] registered, high while a channel is in HOLD or FADE

// Per-channel IDLE/HOLD/FADE sequencer with registered LED/BUSY.
module led_ps_lane #(
  parameter int HOLD_TICKS = 128,
  parameter int PWM_BITS   = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                tick,
  input  logic                trig,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, HOLD, FADE} state_t;

  state_t              state, state_nxt;
  logic [7:0]          hold_cnt, hold_nxt;
  logic [PWM_BITS-1:0] level, level_nxt;
  logic                led_nxt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      hold_cnt <= '0;
      level    <= '0;
      led      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      level    <= level_nxt;
      led      <= led_nxt;
      busy     <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    level_nxt = level;
    if (trig) begin
      // A trigger beats a coincident tick in every state.
      state_nxt = HOLD;
      hold_nxt  = 8'(HOLD_TICKS);
      level_nxt = '1;
    end else if (tick) begin
      case (state)
        HOLD: begin
          // Leave HOLD at 1 so hold_cnt never wraps. Level is already all-ones.
          if (hold_cnt == 8'd1) state_nxt = FADE;
          else                  hold_nxt  = hold_cnt - 8'd1;
        end
        FADE: begin
          if (level == PWM_BITS'(1)) begin
            state_nxt = IDLE;
            level_nxt = '0;
          end else begin
            level_nxt = level - PWM_BITS'(1);
          end
        end
        default: ;
      endcase
    end
    // LED is computed from next-state values so it follows TRIG one cycle later.
    led_nxt = (state_nxt == HOLD) || ((state_nxt == FADE) && (pwm_cnt < level_nxt));
  end
endmodule

module led_pulse_stretcher #(
  parameter int N           = 24,
  parameter int TICK_CYCLES = 195312,
  parameter int HOLD_TICKS  = 128,
  parameter int PWM_BITS    = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         EN,
  input  logic [N-1:0] TRIG,
  output logic [N-1:0] LED,
  output logic [N-1:0] BUSY
);
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [PW-1:0]       pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;

  assign tick = EN && (pre_cnt == PW'(TICK_CYCLES - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      if (EN) pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    led_ps_lane #(
      .HOLD_TICKS (HOLD_TICKS),
      .PWM_BITS   (PWM_BITS)
    ) u_lane (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .tick    (tick),
      .trig    (TRIG[i]),
      .pwm_cnt (pwm_cnt),
      .led     (LED[i]),
      .busy    (BUSY[i])
    );
  end
endmodule

// File: tb/tb_led_pulse_stretcher.sv
module tb_led_pulse_stretcher;
  localparam int N  = 4;
  localparam int TC = 4;
  localparam int HT = 3;
  localparam int PB = 3;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         EN = 1'b0;
  logic [N-1:0] TRIG = '0;
  logic [N-1:0] LED, BUSY;

  led_pulse_stretcher #(.N(N), .TICK_CYCLES(TC), .HOLD_TICKS(HT), .PWM_BITS(PB)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .TRIG(TRIG), .LED(LED), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [N-1:0] led;
    logic [N-1:0] busy;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [N-1:0] trig;
    logic         en;
    logic [N-1:0] led;
    logic [N-1:0] busy;
  } vec_t;

  // Reference model state: st 0=IDLE 1=HOLD 2=FADE
  int   m_pcnt, m_pwm;
  int   m_st[N], m_hc[N], m_lv[N];
  logic m_tick;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pcnt = 0; m_pwm = 0; m_tick = 1'b0;
    for (int i = 0; i < N; i++) begin m_st[i] = 0; m_hc[i] = 0; m_lv[i] = 0; end
    sb_q.delete();
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < N; i++) if (m_st[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Called at a negedge; drives one cycle, scores it, returns at the next negedge.
  task automatic step(input logic [N-1:0] trig, input logic en);
    exp_t e;
    TRIG = trig; EN = en;
    m_tick = en && (m_pcnt == TC - 1);
    for (int i = 0; i < N; i++) begin
      if (trig[i]) begin
        m_st[i] = 1; m_hc[i] = HT; m_lv[i] = (1 << PB) - 1;
      end else if (m_tick) begin
        if (m_st[i] == 1) begin
          if (m_hc[i] == 1) m_st[i] = 2; else m_hc[i] = m_hc[i] - 1;
        end else if (m_st[i] == 2) begin
          if (m_lv[i] == 1) begin m_st[i] = 0; m_lv[i] = 0; end
          else m_lv[i] = m_lv[i] - 1;
        end
      end
      e.led[i]  = (m_st[i] == 1) || ((m_st[i] == 2) && (m_pwm < m_lv[i]));
      e.busy[i] = (m_st[i] != 0);
    end
    if (en) m_pcnt = (m_pcnt == TC - 1) ? 0 : m_pcnt + 1;
    m_pwm = (m_pwm + 1) % (1 << PB);
    sb_q.push_back(e);
    @(posedge CLK); #1;
    e = sb_q.pop_front();
    check("sb_led", 32'(LED), 32'(e.led));
    check("sb_busy", 32'(BUSY), 32'(e.busy));
    @(negedge CLK);
  endtask

  // Called at a negedge; asserts reset, checks the async clear, releases at a negedge.
  task automatic reset_dut();
    TRIG = '0;
    RST_N = 1'b0;
    #1;
    check("rst_led", 32'(LED), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (all_idle()) begin ok = 1'b1; break; end
      step('0, 1'b1);
    end
    check(name, 32'(ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   cnt, lit;
    bit   found;
    int   t0, t1, t2, t3;

    // Hand-derived vectors starting right after reset (prescaler at 0).
    vecs[0] = '{4'b0001, 1'b1, 4'b0001, 4'b0001};
    vecs[1] = '{4'b0000, 1'b1, 4'b0001, 4'b0001};
    vecs[2] = '{4'b0000, 1'b1, 4'b0001, 4'b0001};
    vecs[3] = '{4'b0000, 1'b1, 4'b0001, 4'b0001};
    vecs[4] = '{4'b0010, 1'b1, 4'b0011, 4'b0011};
    vecs[5] = '{4'b0000, 1'b0, 4'b0011, 4'b0011};
    vecs[6] = '{4'b0000, 1'b1, 4'b0011, 4'b0011};
    vecs[7] = '{4'b1100, 1'b1, 4'b1111, 4'b1111};

    @(negedge CLK);
    reset_dut();

    // Single trigger from prescaler phase 0: 3 cycles to first tick, then 9 more ticks.
    step(4'b0001, 1'b1);
    cnt = 1;
    for (int c = 0; c < 100; c++) begin
      step('0, 1'b1);
      if (BUSY[0]) cnt++; else break;
    end
    check("single_busy_cycles", 32'(cnt), 32'd39);
    check("single_led_off", 32'(LED[0]), 32'd0);

    // Table vectors
    reset_dut();
    for (int v = 0; v < 8; v++) begin
      step(vecs[v].trig, vecs[v].en);
      check("vec_led", 32'(LED), 32'(vecs[v].led));
      check("vec_busy", 32'(BUSY), 32'(vecs[v].busy));
    end
    wait_idle("vec_idle");

    // Retrigger during FADE at level 4
    step(4'b0010, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (m_st[1] == 2 && m_lv[1] == 4) begin found = 1'b1; break; end
      step('0, 1'b1);
    end
    check("retrig_reach", 32'(found), 32'd1);
    step(4'b0010, 1'b1);
    check("retrig_led", 32'(LED[1]), 32'd1);
    check("retrig_busy", 32'(BUSY[1]), 32'd1);
    wait_idle("retrig_idle");

    // Trigger coincident with the tick that would end HOLD
    step(4'b0100, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (m_st[2] == 1 && m_hc[2] == 1 && m_pcnt == TC - 1) begin found = 1'b1; break; end
      step('0, 1'b1);
    end
    check("trigtick_reach", 32'(found), 32'd1);
    step(4'b0100, 1'b1);
    lit = 0;
    for (int c = 0; c < 10; c++) begin
      step('0, 1'b1);
      lit += int'(LED[2]);
    end
    check("trigtick_solid", 32'(lit), 32'd10);
    wait_idle("trigtick_idle");

    // Freeze during FADE at level 5
    step(4'b1000, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (m_st[3] == 2 && m_lv[3] == 5) begin found = 1'b1; break; end
      step('0, 1'b1);
    end
    check("freeze_reach", 32'(found), 32'd1);
    lit = 0;
    for (int c = 0; c < 96; c++) begin
      step('0, 1'b0);
      lit += int'(LED[3]);
    end
    check("freeze_duty", 32'(lit), 32'd60);
    for (int c = 0; c < 4; c++) step('0, 1'b0);
    check("freeze_busy", 32'(BUSY[3]), 32'd1);
    wait_idle("freeze_idle");

    // Independence: all four, then ch2 again two ticks later
    step(4'b1111, 1'b1);
    cnt = 0;
    for (int c = 0; c < 20 && cnt < 2; c++) begin
      step('0, 1'b1);
      if (m_tick) cnt++;
    end
    check("indep_ticks", 32'(cnt), 32'd2);
    step(4'b0100, 1'b1);
    t0 = -1; t1 = -1; t2 = -1; t3 = -1;
    for (int c = 0; c < 200; c++) begin
      step('0, 1'b1);
      if (t0 < 0 && !BUSY[0]) t0 = c;
      if (t1 < 0 && !BUSY[1]) t1 = c;
      if (t2 < 0 && !BUSY[2]) t2 = c;
      if (t3 < 0 && !BUSY[3]) t3 = c;
      if (t2 >= 0) break;
    end
    check("indep_ch1_vs_ch0", 32'(t1 - t0), 32'd0);
    check("indep_ch3_vs_ch0", 32'(t3 - t0), 32'd0);
    check("indep_ch2_lag", 32'(t2 - t0), 32'd8);
    check("indep_ch0_done", 32'(t0 >= 0), 32'd1);

    // Reset mid-activity, then no residual activity
    step(4'b1111, 1'b1);
    for (int c = 0; c < 17; c++) step('0, 1'b1);
    check("midrst_busy_before", 32'(BUSY), 32'hF);
    reset_dut();
    lit = 0;
    for (int c = 0; c < 40; c++) begin
      step('0, 1'b1);
      lit += int'(|{LED, BUSY});
    end
    check("midrst_quiet", 32'(lit), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
